// File: rtl/cam_pkg.sv
// cam_pkg
// Shared types and constants for the camera source emulator.
//   state_t  : frame sequencer states
//   mode_t   : test pattern select
//   BAR      : RGB565 colours of the eight vertical bars, left to right
//   DEF_*    : default timing for a 640x480 RGB565 sensor
package cam_pkg;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_BLANK  = 144;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BACK   = 17;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        BACK   = 3'd2,
        ACTIVE = 3'd3,
        FRONT  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_GRID  = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_ZERO  = 2'd3
    } mode_t;

    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [15:0] BAR [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

endpackage

// File: rtl/cam_pattern_gen.sv
// cam_pattern_gen
// Produces the pixel byte for the current bus position.
//   clk, rst_n : system clock, synchronous active-low reset
//   clear      : zero the frame byte counter (frame start)
//   tick       : pclk falling-edge strobe from the sequencer
//   active     : current position is an active byte (href high)
//   mode       : latched pattern select
//   a          : low bits of the active line index
//   c          : column counter
//   d          : pattern byte, 0 outside active bytes
module cam_pattern_gen
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int CW       = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          tick,
    input  logic          active,
    input  mode_t         mode,
    input  logic [3:0]    a,
    input  logic [CW-1:0] c,
    output logic [7:0]    d
);

    logic [7:0]  byte_cnt;
    logic [2:0]  bar_idx;
    logic [15:0] bar_rgb;
    logic [7:0]  pattern;

    // The byte counter advances when an active byte is retired, so the
    // first active byte of a frame shows 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt <= 8'h00;
        end else if (clear) begin
            byte_cnt <= 8'h00;
        end else if (tick && active) begin
            byte_cnt <= byte_cnt + 8'd1;
        end
    end

    // Bar width H_ACTIVE/8 is generally not a power of two, so the bar
    // index is found with threshold compares instead of a divider.
    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (c >= CW'(i * H_ACTIVE / 8)) begin
                bar_idx = 3'(i);
            end
        end
        bar_rgb = BAR[bar_idx];

        case (mode)
            MODE_COUNT: pattern = byte_cnt;
            MODE_GRID:  pattern = {a, c[3:0]};
            MODE_BARS:  pattern = c[0] ? bar_rgb[7:0] : bar_rgb[15:8];
            default:    pattern = 8'h00;
        endcase

        d = active ? pattern : 8'h00;
    end

endmodule

// File: rtl/camera_source_emulator.sv
// camera_source_emulator
// Synthesizable parallel-camera source: emits whole frames of a selectable
// test pattern on a pclk/vsync/href/d bus while enabled.
//   clk, rst_n  : system clock, synchronous active-low reset
//   enable      : frames are generated while high
//   mode        : pattern select, latched at each frame start
//   pclk        : pixel clock, clk/2 while busy, 0 when idle
//   vsync, href : frame sync and line valid, active high
//   d           : pixel byte
//   busy        : high from frame start to frame end
//   frame_done  : one-clk pulse after the last tick of a frame
module camera_source_emulator
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] mode,
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [7:0] d,
    output logic       busy,
    output logic       frame_done
);

    localparam int LINE_LEN = H_ACTIVE + H_BLANK;
    localparam int CW       = $clog2(LINE_LEN);
    localparam int LW_RAW   = $clog2(V_SYNC + V_BACK + V_ACTIVE + V_FRONT);
    localparam int LW       = (LW_RAW < 4) ? 4 : LW_RAW;

    localparam logic [CW-1:0] COL_LAST    = CW'(LINE_LEN - 1);
    localparam logic [CW-1:0] COL_ACTIVE  = CW'(H_ACTIVE);
    localparam logic [LW-1:0] SYNC_LAST   = LW'(V_SYNC - 1);
    localparam logic [LW-1:0] BACK_LAST   = LW'(V_BACK - 1);
    localparam logic [LW-1:0] ACTIVE_LAST = LW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] FRONT_LAST  = LW'(V_FRONT - 1);

    state_t        state, state_d;
    logic [CW-1:0] col_cnt;
    logic [LW-1:0] line_cnt;
    mode_t         mode_q;
    logic          tick, line_end, last_line, frame_end, start, in_active;

    // A tick is the clk edge where pclk falls; everything the receiver
    // samples changes only there, so it is stable at the next pclk rise.
    always_comb begin
        tick     = (state != IDLE) && pclk;
        line_end = tick && (col_cnt == COL_LAST);
        case (state)
            SYNC:    last_line = (line_cnt == SYNC_LAST);
            BACK:    last_line = (line_cnt == BACK_LAST);
            ACTIVE:  last_line = (line_cnt == ACTIVE_LAST);
            FRONT:   last_line = (line_cnt == FRONT_LAST);
            default: last_line = 1'b0;
        endcase
        frame_end = (state == FRONT) && line_end && last_line;
        start     = enable && ((state == IDLE) || frame_end);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (enable)                state_d = SYNC;
            SYNC:    if (line_end && last_line) state_d = BACK;
            BACK:    if (line_end && last_line) state_d = ACTIVE;
            ACTIVE:  if (line_end && last_line) state_d = FRONT;
            FRONT:   if (line_end && last_line) state_d = enable ? SYNC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vsync     = (state == SYNC);
        in_active = (state == ACTIVE) && (col_cnt < COL_ACTIVE);
        href      = in_active;
        busy      = (state != IDLE);
    end

    // pclk stays low on the IDLE->SYNC edge, so the first toggle is a rise
    // and the first tick is the following falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pclk <= 1'b0;
        end else if (state == IDLE) begin
            pclk <= 1'b0;
        end else begin
            pclk <= ~pclk;
        end
    end

    // line_cnt restarts at 0 whenever a line wrap also changes state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_cnt  <= '0;
            line_cnt <= '0;
        end else if (tick) begin
            if (col_cnt == COL_LAST) begin
                col_cnt  <= '0;
                line_cnt <= (state_d != state) ? '0 : line_cnt + LW'(1);
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= MODE_COUNT;
            frame_done <= 1'b0;
        end else begin
            if (start) begin
                mode_q <= mode_t'(mode);
            end
            frame_done <= frame_end;
        end
    end

    cam_pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .CW       (CW)
    ) u_pattern (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start),
        .tick   (tick),
        .active (in_active),
        .mode   (mode_q),
        .a      (line_cnt[3:0]),
        .c      (col_cnt),
        .d      (d)
    );

endmodule

// File: tb/tb_camera_source_emulator.sv
// tb_camera_source_emulator
// Self-checking bench for camera_source_emulator with small timing.
// A monitor records {vsync, href, d} at every pclk rising edge; frames are
// compared against a reference built from nested line/column loops, and
// against a table of hand-derived byte values.
module tb_camera_source_emulator;

    localparam int H_ACTIVE     = 16;
    localparam int H_BLANK      = 4;
    localparam int V_SYNC       = 1;
    localparam int V_BACK       = 1;
    localparam int V_ACTIVE     = 2;
    localparam int V_FRONT      = 1;
    localparam int LINE_LEN     = H_ACTIVE + H_BLANK;
    localparam int TOTAL_LINES  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int FIRST_ACTIVE = V_SYNC + V_BACK;

    typedef struct {
        int         mode;
        int         a;
        int         c;
        logic       href;
        logic [7:0] d;
    } tv_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] mode;
    logic       pclk, vsync, href, busy, frame_done;
    logic [7:0] d;

    int n_compared   = 0;
    int n_mismatched = 0;
    int done_count   = 0;

    logic [9:0]  mon_q[$];
    logic [9:0]  exp_q[$];
    tv_t         tv_q[$];
    logic        prev_pclk  = 1'b0;
    logic [9:0]  prev_bus   = '0;
    logic [1:0]  done_state = '0;
    logic [15:0] bar_tb [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic [7:0]  bars_line0 [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                     8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    camera_source_emulator #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode       (mode),
        .pclk       (pclk),
        .vsync      (vsync),
        .href       (href),
        .d          (d),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Sampling on the falling clk edge keeps us away from the active edge.
    // A pclk rise is seen as pclk 0 on the previous sample and 1 now; the
    // bus must not have moved since the sample taken after the fall.
    always @(negedge clk) begin
        if (pclk && !prev_pclk) begin
            check_output("bus stable at pclk rise", {22'd0, vsync, href, d}, {22'd0, prev_bus});
            mon_q.push_back({vsync, href, d});
        end
        if (frame_done) begin
            done_count++;
            done_state = {busy, vsync};
        end
        prev_pclk = pclk;
        prev_bus  = {vsync, href, d};
    end

    task automatic apply_stimulus(input int m, input logic en);
        @(negedge clk);
        mode   = 2'(m);
        enable = en;
    endtask

    task automatic wait_done(input int target, input string tag);
        int cyc;
        cyc = 0;
        while (done_count < target && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        check_output({tag, " frame_done reached"}, 32'(done_count >= target), 1);
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int cyc;
        cyc = 0;
        while (mon_q.size() < n && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        check_output({tag, " bytes reached"}, 32'(mon_q.size() >= n), 1);
    endtask

    // Reference frame: one entry per pclk rise, walked line by line.
    task automatic push_model(input int m);
        int          k, a;
        logic        vs, hr;
        logic [7:0]  dv;
        logic [15:0] rgb;
        k = 0;
        for (int ln = 0; ln < TOTAL_LINES; ln++) begin
            for (int c = 0; c < LINE_LEN; c++) begin
                a  = ln - FIRST_ACTIVE;
                vs = (ln < V_SYNC);
                hr = (a >= 0) && (a < V_ACTIVE) && (c < H_ACTIVE);
                dv = 8'h00;
                if (hr) begin
                    case (m)
                        0: dv = 8'(k % 256);
                        1: dv = 8'((a % 16) * 16 + (c % 16));
                        2: begin
                            rgb = bar_tb[c / (H_ACTIVE / 8)];
                            dv  = (c % 2 == 0) ? rgb[15:8] : rgb[7:0];
                        end
                        default: dv = 8'h00;
                    endcase
                    k++;
                end
                exp_q.push_back({vs, hr, dv});
            end
        end
    endtask

    task automatic compare_model(input string tag);
        int n;
        check_output({tag, " edge count"}, mon_q.size(), exp_q.size());
        n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_output($sformatf("%s pos %0d", tag, i), {22'd0, mon_q[i]}, {22'd0, exp_q[i]});
        end
    endtask

    task automatic run_frame(input int m, input string tag);
        int d0;
        mon_q.delete();
        d0 = done_count;
        apply_stimulus(m, 1'b1);
        apply_stimulus(m, 1'b0);
        wait_done(d0 + 1, tag);
        repeat (4) @(negedge clk);
        check_output({tag, " done pulses"}, done_count - d0, 1);
        check_output({tag, " state at done"}, {30'd0, done_state}, 0);
        check_output({tag, " idle bus"}, {19'd0, pclk, busy, vsync, href, d}, 0);
    endtask

    task automatic add_tv(input int m, input int a, input int c, input logic hr,
                          input logic [7:0] dv);
        tv_t t;
        t.mode = m; t.a = a; t.c = c; t.href = hr; t.d = dv;
        tv_q.push_back(t);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0, idx, vs_n, hr_n;
        logic [9:0] got;

        add_tv(0, 0, 0, 1'b1, 8'h00);
        add_tv(0, 0, 15, 1'b1, 8'h0F);
        add_tv(0, 1, 0, 1'b1, 8'h10);
        add_tv(0, 1, 15, 1'b1, 8'h1F);
        add_tv(0, 0, 16, 1'b0, 8'h00);
        add_tv(1, 1, 5, 1'b1, 8'h15);
        add_tv(1, 0, 3, 1'b1, 8'h03);
        add_tv(1, 1, 16, 1'b0, 8'h00);
        add_tv(1, 1, 19, 1'b0, 8'h00);
        for (int c = 0; c < 16; c++) add_tv(2, 0, c, 1'b1, bars_line0[c]);
        add_tv(2, 1, 2, 1'b1, 8'hFF);
        add_tv(3, 0, 7, 1'b1, 8'h00);

        rst_n  = 1'b0;
        enable = 1'b0;
        mode   = 2'd0;
        repeat (3) @(negedge clk);
        check_output("reset outputs", {19'd0, pclk, vsync, href, d, busy, frame_done}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_output("idle after reset", {19'd0, pclk, vsync, href, d, busy, frame_done}, 0);

        // One single-shot frame per mode, then the hand-derived table.
        for (int m = 0; m < 4; m++) begin
            run_frame(m, $sformatf("mode%0d", m));
            vs_n = 0;
            hr_n = 0;
            foreach (mon_q[i]) begin
                if (mon_q[i][9]) vs_n++;
                if (mon_q[i][8]) hr_n++;
            end
            check_output($sformatf("mode%0d vsync edges", m), vs_n, V_SYNC * LINE_LEN);
            check_output($sformatf("mode%0d href edges", m), hr_n, V_ACTIVE * H_ACTIVE);
            exp_q.delete();
            push_model(m);
            compare_model($sformatf("mode%0d model", m));
            foreach (tv_q[t]) begin
                if (tv_q[t].mode == m) begin
                    idx = (FIRST_ACTIVE + tv_q[t].a) * LINE_LEN + tv_q[t].c;
                    got = (idx < mon_q.size()) ? mon_q[idx] : 10'h3FF;
                    check_output($sformatf("tv mode%0d a%0d c%0d", m, tv_q[t].a, tv_q[t].c),
                                 {22'd0, got}, {22'd0, 1'b0, tv_q[t].href, tv_q[t].d});
                end
            end
        end

        // Continuous: mode change mid-frame only takes effect next frame,
        // and the second vsync follows with no idle gap.
        $display("[TB] continuous frames");
        mon_q.delete();
        exp_q.delete();
        d0 = done_count;
        apply_stimulus(1, 1'b1);
        wait_bytes(50, "cont");
        apply_stimulus(2, 1'b1);
        wait_done(d0 + 1, "cont first");
        check_output("cont back-to-back", {30'd0, done_state}, 2'b11);
        apply_stimulus(2, 1'b0);
        wait_done(d0 + 2, "cont second");
        repeat (4) @(negedge clk);
        check_output("cont final state", {30'd0, done_state}, 0);
        check_output("cont idle bus", {19'd0, pclk, busy, vsync, href, d}, 0);
        push_model(1);
        push_model(2);
        compare_model("cont model");

        // Reset during active line 1, then a clean frame.
        $display("[TB] reset mid-frame");
        mon_q.delete();
        d0 = done_count;
        apply_stimulus(0, 1'b1);
        apply_stimulus(0, 1'b0);
        wait_bytes((FIRST_ACTIVE + 1) * LINE_LEN + 6, "reset");
        @(negedge clk);
        check_output("pre-reset busy/href", {30'd0, busy, href}, 2'b11);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("reset mid-frame outputs", {19'd0, pclk, vsync, href, d, busy, frame_done}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_output("no frame_done after reset", done_count, d0);
        check_output("idle after mid reset", {19'd0, pclk, vsync, href, d, busy, frame_done}, 0);
        run_frame(0, "post-reset");
        exp_q.delete();
        push_model(0);
        compare_model("post-reset model");

        // Random modes with random idle gaps.
        for (int r = 0; r < 5; r++) begin
            int m;
            repeat ($urandom_range(1, 6)) @(negedge clk);
            m = $urandom_range(0, 3);
            run_frame(m, $sformatf("rand%0d", r));
            exp_q.delete();
            push_model(m);
            compare_model($sformatf("rand%0d model m%0d", r, m));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
